id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of PC and operands.
REQ-002 SHALL have clk_i  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have if_valid_i  input  1, if_instr_i  input  32, if_pc_i  input  XLEN; fetch-side instruction and PC.
REQ-005 SHALL have if_ready_o  output  1; stage accepts the fetch word this cycle.
REQ-006 SHALL have rf_raddr1_o  output  5, rf_raddr2_o  output  5; combinational rs1/rs2 fields to the register file.
REQ-007 SHALL have rf_rdata1_i  input  XLEN, rf_rdata2_i  input  XLEN; combinational register file read data, write-bypass included.
REQ-008 SHALL have flush_i  input  1; branch/jump redirect from execute.
REQ-009 SHALL have ex_ready_i  input  1; execute accepts the held entry.
REQ-010 SHALL have ex_valid_o  output  1, ex_pc_o  output  XLEN, ex_rs1_o  output  XLEN, ex_rs2_o  output  XLEN, ex_imm_o  output  XLEN, ex_rd_o  output  5, ex_alu_op_o  output  4, ex_wb_en_o  output  1, ex_mem_rd_o  output  1, ex_mem_wr_o  output  1; registered ID/EX entry.

Function
REQ-011 SHALL decode opcodes LUI 0110111, OP-IMM 0010011, OP 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011; any other opcode decodes as NOP (ex_wb_en_o=0, ex_mem_rd_o=0, ex_mem_wr_o=0).
REQ-012 SHALL sign-extend I/S/B immediates to XLEN; LUI immediate = sign-extended instr[31:12]<<12; B immediate bit0=0.
REQ-013 SHALL drive rf_raddr1_o=instr[19:15], rf_raddr2_o=instr[24:20] from if_instr_i every cycle regardless of valid.
REQ-014 SHALL treat rs1 as used for OP-IMM, OP, LOAD, STORE, BRANCH; rs2 as used for OP, STORE, BRANCH.
REQ-015 SHALL assert load_use when ex_valid_o=1, ex_mem_rd_o=1, ex_rd_o!=0, and ex_rd_o equals a used rs of if_instr_i.
REQ-016 SHALL set if_ready_o = !flush_i ? (!load_use && (!ex_valid_o || ex_ready_i)) : 1.
REQ-017 SHALL capture decoded entry plus rf_rdata into ID/EX register on handshake (if_valid_i && if_ready_o && !flush_i); latency one cycle.
REQ-018 SHALL hold the ID/EX register unchanged while ex_valid_o=1 and ex_ready_i=0.
REQ-019 SHALL insert a bubble (ex_valid_o=0 next cycle) when ex_ready_i=1 and load_use=1 or if_valid_i=0.
REQ-020 SHALL on flush_i clear ex_valid_o next cycle, discard the fetch word, and ignore ex_ready_i and load_use; flush wins all simultaneous events.
REQ-021 SHALL force ex_wb_en_o=0 when the decoded rd is 0.

Reset
REQ-022 SHALL on rst_i=1 at posedge clear ex_valid_o, ex_wb_en_o, ex_mem_rd_o, ex_mem_wr_o, ex_rd_o, ex_alu_op_o, and zero ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o.
REQ-023 SHALL discard any held entry when reset asserts mid-stall; if_ready_o=1 in the first cycle after reset release.

Configuration
REQ-024 SHALL with ID_ILLEGAL_TRAP_EN defined add output ex_illegal_o 1-bit, registered with the entry, set for undecoded opcodes and reset to 0; without it the port is absent and such opcodes are silent NOPs.

Verification
REQ-025 SHALL cover: rst_i high 2 cycles then low -> ex_valid_o=0, if_ready_o=1, all ex_* zero.
REQ-026 SHALL cover: ADDI x5,x1,-3 with rf_rdata1_i=10 -> next cycle ex_valid_o=1, ex_rs1_o=10, ex_imm_o=0xFFFF_FFFF_FFFF_FFFD, ex_rd_o=5, ex_wb_en_o=1.
REQ-027 SHALL cover: LD x6 then ADD x7,x6,x2 back-to-back, ex_ready_i=1 -> if_ready_o=0 one cycle, one bubble, ADD issues on the following cycle.
REQ-028 SHALL cover: ex_ready_i=0 for 3 cycles with valid entry held -> ex_* outputs stable, if_ready_o=0, then entry advances on ex_ready_i=1.
REQ-029 SHALL cover: flush_i=1 together with load_use and ex_ready_i=0 -> next cycle ex_valid_o=0, fetch word not captured.
REQ-030 SHALL cover: ADDI x0,x0,1 -> ex_wb_en_o=0; with ID_ILLEGAL_TRAP_EN, opcode 1111111 -> ex_illegal_o=1.

Source files
------------

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage with a single ID/EX pipeline register
//
// Decodes one fetched RV instruction per cycle and registers it, together with
// its register-file operands, into the ID/EX entry consumed by execute.
// Stalls on a load-use hazard against the held entry and on execute
// back-pressure. A flush from execute discards both the held entry and the
// incoming fetch word.
//
// Optional feature macro: ID_ILLEGAL_TRAP_EN adds ex_illegal_o. When the macro
// is not defined, undecoded opcodes become silent NOPs.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   if_valid_i/if_instr_i/if_pc_i     fetch word and its PC
//   if_ready_o                        fetch word is accepted this cycle
//   rf_raddr1_o/rf_raddr2_o           rs1/rs2 fields, always taken from if_instr_i
//   rf_rdata1_i/rf_rdata2_i           register file read data (bypass included)
//   flush_i                           redirect from execute, wins all events
//   ex_ready_i                        execute takes the held entry
//   ex_*_o                            registered ID/EX entry
//
// ex_alu_op_o encoding: OP and OP-IMM use {funct7[5], funct3}, where OP-IMM only
// keeps funct7[5] for the shift-right group (funct3=101); LOAD/STORE use ADD
// (0000); BRANCH uses SUB (1000); LUI uses pass-immediate (1111).
module id_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_valid_i,
   input  logic [31:0]     if_instr_i,
   input  logic [XLEN-1:0] if_pc_i,
   output logic            if_ready_o,
   output logic [4:0]      rf_raddr1_o,
   output logic [4:0]      rf_raddr2_o,
   input  logic [XLEN-1:0] rf_rdata1_i,
   input  logic [XLEN-1:0] rf_rdata2_i,
   input  logic            flush_i,
   input  logic            ex_ready_i,
   output logic            ex_valid_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [XLEN-1:0] ex_rs1_o,
   output logic [XLEN-1:0] ex_rs2_o,
   output logic [XLEN-1:0] ex_imm_o,
   output logic [4:0]      ex_rd_o,
   output logic [3:0]      ex_alu_op_o,
   output logic            ex_wb_en_o,
   output logic            ex_mem_rd_o,
`ifdef ID_ILLEGAL_TRAP_EN
   output logic            ex_mem_wr_o,
   output logic            ex_illegal_o
`else
   output logic            ex_mem_wr_o
`endif
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_PASS = 4'b1111;

   // ------------------------------------------------------------------
   // Field extraction and immediates
   // ------------------------------------------------------------------
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1_idx;
   logic [4:0]      rs2_idx;
   logic [4:0]      rd_idx;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;

   assign opcode  = if_instr_i[6:0];
   assign funct3  = if_instr_i[14:12];
   assign rs1_idx = if_instr_i[19:15];
   assign rs2_idx = if_instr_i[24:20];
   assign rd_idx  = if_instr_i[11:7];

   assign imm_i = XLEN'($signed(if_instr_i[31:20]));
   assign imm_s = XLEN'($signed({if_instr_i[31:25], if_instr_i[11:7]}));
   assign imm_b = XLEN'($signed({if_instr_i[31], if_instr_i[7], if_instr_i[30:25],
                                 if_instr_i[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({if_instr_i[31:12], 12'b0}));

   assign rf_raddr1_o = rs1_idx;
   assign rf_raddr2_o = rs2_idx;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [XLEN-1:0] dec_imm;
   logic [3:0]      dec_alu_op;
   logic            dec_wb_en;
   logic            dec_mem_rd;
   logic            dec_mem_wr;
   logic            rs1_used;
   logic            rs2_used;

   always_comb begin
      dec_imm    = '0;
      dec_alu_op = ALU_ADD;
      dec_wb_en  = 1'b0;
      dec_mem_rd = 1'b0;
      dec_mem_wr = 1'b0;
      rs1_used   = 1'b0;
      rs2_used   = 1'b0;
      case (opcode)
         OPC_LUI: begin
            dec_imm    = imm_u;
            dec_alu_op = ALU_PASS;
            dec_wb_en  = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_imm    = imm_i;
            dec_alu_op = {(funct3 == 3'b101) && if_instr_i[30], funct3};
            dec_wb_en  = 1'b1;
            rs1_used   = 1'b1;
         end
         OPC_OP: begin
            dec_alu_op = {if_instr_i[30], funct3};
            dec_wb_en  = 1'b1;
            rs1_used   = 1'b1;
            rs2_used   = 1'b1;
         end
         OPC_LOAD: begin
            dec_imm    = imm_i;
            dec_wb_en  = 1'b1;
            dec_mem_rd = 1'b1;
            rs1_used   = 1'b1;
         end
         OPC_STORE: begin
            dec_imm    = imm_s;
            dec_mem_wr = 1'b1;
            rs1_used   = 1'b1;
            rs2_used   = 1'b1;
         end
         OPC_BRANCH: begin
            dec_imm    = imm_b;
            dec_alu_op = ALU_SUB;
            rs1_used   = 1'b1;
            rs2_used   = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef ID_ILLEGAL_TRAP_EN
   logic dec_illegal;
   assign dec_illegal = !(opcode inside {OPC_LUI, OPC_OP_IMM, OPC_OP,
                                         OPC_LOAD, OPC_STORE, OPC_BRANCH});
`endif

   // ------------------------------------------------------------------
   // ID/EX register and handshake
   // ------------------------------------------------------------------
   logic            ex_valid_q,  ex_valid_d;
   logic [XLEN-1:0] ex_pc_q,     ex_pc_d;
   logic [XLEN-1:0] ex_rs1_q,    ex_rs1_d;
   logic [XLEN-1:0] ex_rs2_q,    ex_rs2_d;
   logic [XLEN-1:0] ex_imm_q,    ex_imm_d;
   logic [4:0]      ex_rd_q,     ex_rd_d;
   logic [3:0]      ex_alu_op_q, ex_alu_op_d;
   logic            ex_wb_en_q,  ex_wb_en_d;
   logic            ex_mem_rd_q, ex_mem_rd_d;
   logic            ex_mem_wr_q, ex_mem_wr_d;
`ifdef ID_ILLEGAL_TRAP_EN
   logic            ex_illegal_q, ex_illegal_d;
`endif

   logic load_use;
   logic slot_free;
   logic capture;

   // The held entry is a load whose result is not yet available to a
   // consumer sitting in decode.
   assign load_use = ex_valid_q && ex_mem_rd_q && (ex_rd_q != 5'd0) &&
                     ((rs1_used && (rs1_idx == ex_rd_q)) ||
                      (rs2_used && (rs2_idx == ex_rd_q)));

   assign slot_free  = !ex_valid_q || ex_ready_i;
   assign if_ready_o = flush_i ? 1'b1 : (!load_use && slot_free);
   assign capture    = if_valid_i && if_ready_o && !flush_i;

   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_pc_d     = ex_pc_q;
      ex_rs1_d    = ex_rs1_q;
      ex_rs2_d    = ex_rs2_q;
      ex_imm_d    = ex_imm_q;
      ex_rd_d     = ex_rd_q;
      ex_alu_op_d = ex_alu_op_q;
      ex_wb_en_d  = ex_wb_en_q;
      ex_mem_rd_d = ex_mem_rd_q;
      ex_mem_wr_d = ex_mem_wr_q;
`ifdef ID_ILLEGAL_TRAP_EN
      ex_illegal_d = ex_illegal_q;
`endif
      if (flush_i) begin
         ex_valid_d = 1'b0;
      end else if (capture) begin
         ex_valid_d  = 1'b1;
         ex_pc_d     = if_pc_i;
         ex_rs1_d    = rf_rdata1_i;
         ex_rs2_d    = rf_rdata2_i;
         ex_imm_d    = dec_imm;
         ex_rd_d     = rd_idx;
         ex_alu_op_d = dec_alu_op;
         ex_wb_en_d  = dec_wb_en && (rd_idx != 5'd0);
         ex_mem_rd_d = dec_mem_rd;
         ex_mem_wr_d = dec_mem_wr;
`ifdef ID_ILLEGAL_TRAP_EN
         ex_illegal_d = dec_illegal;
`endif
      end else if (slot_free) begin
         // Execute drained the entry but nothing new enters: bubble.
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_valid_q  <= 1'b0;
         ex_pc_q     <= '0;
         ex_rs1_q    <= '0;
         ex_rs2_q    <= '0;
         ex_imm_q    <= '0;
         ex_rd_q     <= '0;
         ex_alu_op_q <= '0;
         ex_wb_en_q  <= 1'b0;
         ex_mem_rd_q <= 1'b0;
         ex_mem_wr_q <= 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
         ex_illegal_q <= 1'b0;
`endif
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_pc_q     <= ex_pc_d;
         ex_rs1_q    <= ex_rs1_d;
         ex_rs2_q    <= ex_rs2_d;
         ex_imm_q    <= ex_imm_d;
         ex_rd_q     <= ex_rd_d;
         ex_alu_op_q <= ex_alu_op_d;
         ex_wb_en_q  <= ex_wb_en_d;
         ex_mem_rd_q <= ex_mem_rd_d;
         ex_mem_wr_q <= ex_mem_wr_d;
`ifdef ID_ILLEGAL_TRAP_EN
         ex_illegal_q <= ex_illegal_d;
`endif
      end
   end

   assign ex_valid_o  = ex_valid_q;
   assign ex_pc_o     = ex_pc_q;
   assign ex_rs1_o    = ex_rs1_q;
   assign ex_rs2_o    = ex_rs2_q;
   assign ex_imm_o    = ex_imm_q;
   assign ex_rd_o     = ex_rd_q;
   assign ex_alu_op_o = ex_alu_op_q;
   assign ex_wb_en_o  = ex_wb_en_q;
   assign ex_mem_rd_o = ex_mem_rd_q;
   assign ex_mem_wr_o = ex_mem_wr_q;
`ifdef ID_ILLEGAL_TRAP_EN
   assign ex_illegal_o = ex_illegal_q;
`endif

endmodule
